// File: rtl/csr_file.sv
// Machine-mode CSR file: scratch, masked mstatus, 64-bit mcycle/minstret (optional mcountinhibit via CSR_COUNTINHIBIT_EN).
// Latency: read data and illegal are combinational; writes land on the next clk edge.
// Backpressure: none; every presented access completes in its own cycle or is rejected via illegal.
module csr_file #(
    parameter int               XLEN         = 32,
    parameter int               NUM_SCRATCH  = 4,
    parameter logic [XLEN-1:0]  STATUS_WMASK = XLEN'(32'h0000_1888)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            en_rw,
    input  logic [1:0]      rw_mode,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            illegal,
    input  logic            instret_inc
);

    localparam logic [4:0]        LP_NS  = 5'(NUM_SCRATCH);
    localparam logic [2*XLEN-1:0] LP_ONE = (2*XLEN)'(1);

    logic [XLEN-1:0]   r_scratch [NUM_SCRATCH];
    logic [XLEN-1:0]   r_mstatus;
    logic [2*XLEN-1:0] r_mcycle;
    logic [2*XLEN-1:0] r_minstret;

    logic            w_hit_scr;
    logic            w_mapped;
    logic            w_ro;
    logic            w_we;
    logic [XLEN-1:0] w_new;
    logic            w_cy_inh;
    logic            w_ir_inh;

`ifdef CSR_COUNTINHIBIT_EN
    localparam logic [XLEN-1:0] LP_INH_MASK = XLEN'(5);
    logic [XLEN-1:0] r_mcountinhibit;
    assign w_cy_inh = r_mcountinhibit[0];
    assign w_ir_inh = r_mcountinhibit[2];
`else
    assign w_cy_inh = 1'b0;
    assign w_ir_inh = 1'b0;
`endif

    assign w_hit_scr = (addr[11:4] == 8'h34) && ({1'b0, addr[3:0]} < LP_NS);
    assign w_ro      = (addr[11:10] == 2'b11);

    // Address decode and pre-write read mux; unmapped addresses read zero.
    always_comb begin
        rdata    = '0;
        w_mapped = 1'b1;
        case (addr)
            12'h300: rdata = r_mstatus;
`ifdef CSR_COUNTINHIBIT_EN
            12'h320: rdata = r_mcountinhibit;
`endif
            12'hB00, 12'hC00: rdata = r_mcycle[XLEN-1:0];
            12'hB80, 12'hC80: rdata = r_mcycle[2*XLEN-1:XLEN];
            12'hB02, 12'hC02: rdata = r_minstret[XLEN-1:0];
            12'hB82, 12'hC82: rdata = r_minstret[2*XLEN-1:XLEN];
            default: begin
                w_mapped = w_hit_scr;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (w_hit_scr && (addr[3:0] == 4'(i))) rdata = r_scratch[i];
                end
            end
        endcase
    end

    // Reject unmapped targets and any write-type access to the read-only shadows.
    assign illegal = en_rw && (rw_mode != 2'b00) && (!w_mapped || w_ro);
    assign w_we    = en_rw && (rw_mode != 2'b00) && !illegal;

    // Read-modify-write value built from the pre-write read data.
    always_comb begin
        case (rw_mode)
            2'b01:   w_new = wdata;
            2'b10:   w_new = rdata | wdata;
            2'b11:   w_new = rdata & ~wdata;
            default: w_new = rdata;
        endcase
    end

    // Scratch and status registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_mstatus <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
        end else if (w_we) begin
            if (addr == 12'h300) r_mstatus <= w_new & STATUS_WMASK;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_hit_scr && (addr[3:0] == 4'(i))) r_scratch[i] <= w_new;
            end
        end
    end

`ifdef CSR_COUNTINHIBIT_EN
    // Counter inhibit: only CY (bit0) and IR (bit2) are stored.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                        r_mcountinhibit <= '0;
        else if (w_we && addr == 12'h320)   r_mcountinhibit <= w_new & LP_INH_MASK;
    end
`endif

    // mcycle: a write to either half replaces that half and cancels the increment.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                        r_mcycle <= '0;
        else if (w_we && addr == 12'hB00)   r_mcycle[XLEN-1:0] <= w_new;
        else if (w_we && addr == 12'hB80)   r_mcycle[2*XLEN-1:XLEN] <= w_new;
        else if (!w_cy_inh)                 r_mcycle <= r_mcycle + LP_ONE;
    end

    // minstret: same override rule, counting retired instructions.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                        r_minstret <= '0;
        else if (w_we && addr == 12'hB02)   r_minstret[XLEN-1:0] <= w_new;
        else if (w_we && addr == 12'hB82)   r_minstret[2*XLEN-1:XLEN] <= w_new;
        else if (instret_inc && !w_ir_inh)  r_minstret <= r_minstret + LP_ONE;
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: counters, scratch, mstatus mask, illegal decode, reset.
// Inputs change one time unit after a rising edge; outputs are checked before the next edge.
// No backpressure in the DUT, so no bounded waits are needed.
module tb_csr_file;

    logic        clk;
    logic        nreset;
    logic        en_rw;
    logic [1:0]  rw_mode;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        illegal;
    logic        instret_inc;

    int n_tests = 0;
    int n_fail  = 0;

    csr_file dut (
        .clk         (clk),
        .nreset      (nreset),
        .en_rw       (en_rw),
        .rw_mode     (rw_mode),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .illegal     (illegal),
        .instret_inc (instret_inc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] mode, input logic [11:0] a, input logic [31:0] d);
        en_rw   = en;
        rw_mode = mode;
        addr    = a;
        wdata   = d;
        #1;
    endtask

    // Idle read of an address, checked against a hand-computed value.
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        drive(1'b0, 2'b00, a, 32'h0);
        check(tag, rdata, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nreset = 1'b0; en_rw = 1'b0; rw_mode = 2'b00; addr = 12'h0; wdata = 32'h0; instret_inc = 1'b0;
        #12;
        rd("rst_mcycle", 12'hB00, 32'h0);
        check("rst_illegal", {31'h0, illegal}, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0);
        nreset = 1'b1;

        // Ten free-running cycles after reset release.
        repeat (10) tick();
        rd("mcycle_lo_10", 12'hB00, 32'd10);
        rd("mcycle_hi_0", 12'hB80, 32'h0);
        check("idle_illegal", {31'h0, illegal}, 32'h0);

        // Scratch RW then RC.
        drive(1'b1, 2'b01, 12'h340, 32'hA5A5_0000);
        check("scr_rw_pre", rdata, 32'h0);
        check("scr_rw_legal", {31'h0, illegal}, 32'h0);
        tick();
        rd("scr_rw_post", 12'h340, 32'hA5A5_0000);
        drive(1'b1, 2'b11, 12'h340, 32'hFFFF_0000);
        check("scr_rc_pre", rdata, 32'hA5A5_0000);
        tick();
        rd("scr_rc_post", 12'h340, 32'h0);
        drive(1'b1, 2'b10, 12'h343, 32'h0000_000F);
        tick();
        drive(1'b1, 2'b10, 12'h343, 32'h0000_00F0);
        tick();
        rd("scr_rs_accum", 12'h343, 32'h0000_00FF);
        drive(1'b1, 2'b01, 12'h344, 32'h1234_5678);
        check("scr_oob_illegal", {31'h0, illegal}, 32'h1);
        check("scr_oob_rdata", rdata, 32'h0);
        tick();

        // 64-bit mcycle wrap.
        drive(1'b1, 2'b01, 12'hB00, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 2'b01, 12'hB80, 32'hFFFF_FFFF);
        tick();
        rd("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_hi_max", 12'hB80, 32'hFFFF_FFFF);
        tick();
        rd("wrap_lo", 12'hB00, 32'h0);
        rd("wrap_hi", 12'hB80, 32'h0);
        rd("wrap_shadow", 12'hC00, 32'h0);

        // Read-only shadow write is rejected; counter keeps counting.
        drive(1'b1, 2'b10, 12'hC00, 32'h1);
        check("ro_illegal", {31'h0, illegal}, 32'h1);
        tick();
        rd("ro_no_effect", 12'hB00, 32'h1);
        drive(1'b1, 2'b00, 12'hC00, 32'h0);
        check("ro_mode0_legal", {31'h0, illegal}, 32'h0);
        check("ro_mode0_rdata", rdata, 32'h1);
        drive(1'b1, 2'b01, 12'h7C0, 32'hDEAD_BEEF);
        check("unmapped_illegal", {31'h0, illegal}, 32'h1);
        check("unmapped_rdata", rdata, 32'h0);
        tick();

        // mstatus masking.
        drive(1'b1, 2'b01, 12'h300, 32'hFFFF_FFFF);
        check("mstatus_pre", rdata, 32'h0);
        tick();
        rd("mstatus_masked", 12'h300, 32'h0000_1888);
        drive(1'b1, 2'b11, 12'h300, 32'h0000_0008);
        tick();
        rd("mstatus_rc", 12'h300, 32'h0000_1880);
        drive(1'b1, 2'b10, 12'h300, 32'h0);
        check("mstatus_rs0_legal", {31'h0, illegal}, 32'h0);
        tick();
        rd("mstatus_rs0_hold", 12'h300, 32'h0000_1880);

        // minstret counting and write override.
        rd("minstret_0", 12'hB02, 32'h0);
        instret_inc = 1'b1;
        repeat (3) tick();
        instret_inc = 1'b0;
        rd("minstret_3", 12'hB02, 32'd3);
        rd("instret_shadow_3", 12'hC02, 32'd3);
        rd("minstret_hi_0", 12'hB82, 32'h0);
        instret_inc = 1'b1;
        drive(1'b1, 2'b01, 12'hB02, 32'd5);
        tick();
        instret_inc = 1'b0;
        rd("minstret_override", 12'hB02, 32'd5);
        drive(1'b1, 2'b10, 12'hB82, 32'h1);
        tick();
        rd("minstret_hi_set", 12'hB82, 32'h1);
        rd("instreth_shadow", 12'hC82, 32'h1);

        // Counter inhibit (or its absence).
        drive(1'b1, 2'b01, 12'hB00, 32'd100);
        tick();
        rd("mcycle_100", 12'hB00, 32'd100);
        drive(1'b1, 2'b01, 12'h320, 32'h5);
`ifdef CSR_COUNTINHIBIT_EN
        check("inh_legal", {31'h0, illegal}, 32'h0);
        tick();
        rd("inh_read", 12'h320, 32'h5);
        rd("inh_mcycle_101", 12'hB00, 32'd101);
        drive(1'b1, 2'b01, 12'h320, 32'hFFFF_FFFF);
        tick();
        rd("inh_masked", 12'h320, 32'h5);
        instret_inc = 1'b1;
        drive(1'b0, 2'b00, 12'hB00, 32'h0);
        repeat (5) tick();
        instret_inc = 1'b0;
        rd("inh_mcycle_frozen", 12'hB00, 32'd101);
        rd("inh_minstret_frozen", 12'hB02, 32'd5);
        drive(1'b1, 2'b01, 12'hB00, 32'd7);
        tick();
        rd("inh_explicit_write", 12'hB00, 32'd7);
`else
        check("inh_illegal", {31'h0, illegal}, 32'h1);
        check("inh_rdata", rdata, 32'h0);
        tick();
        rd("noinh_mcycle_101", 12'hB00, 32'd101);
        instret_inc = 1'b1;
        repeat (5) tick();
        instret_inc = 1'b0;
        rd("noinh_mcycle_106", 12'hB00, 32'd106);
        rd("noinh_minstret_10", 12'hB02, 32'd10);
`endif

        // Reset in the middle of a write.
        drive(1'b1, 2'b01, 12'h341, 32'h0000_0055);
        tick();
        rd("scr1_written", 12'h341, 32'h0000_0055);
        drive(1'b1, 2'b01, 12'h341, 32'h0000_1234);
        nreset = 1'b0;
        #1;
        check("midrst_scr1", rdata, 32'h0);
        tick();
        nreset = 1'b1;
        rd("postrst_scr1", 12'h341, 32'h0);
        rd("postrst_minstret", 12'hB02, 32'h0);
        rd("postrst_mstatus", 12'h300, 32'h0);
        rd("postrst_mcycle", 12'hB00, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
